// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared types for the load/store data-memory arbiter: the
//                split load/store queue request record and the arbiter FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

   // One request from either the load queue or the store queue.  Stores use
   // addr/wmask/wdata; loads use addr/rmask plus the writeback tags.
   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  rmask;
      logic [3:0]  wmask;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [5:0]  pd;
      logic [3:0]  rob_entry;
      logic [31:0] pc;
   } split_lsq_t;

   // Arbiter FSM states, explicit 2-bit encoding.
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      STORE_WAIT = 2'd1,
      LOAD_WAIT  = 2'd2,
      LOAD_DROP  = 2'd3
   } arb_state_e;

   // Width of a counter able to hold values 0..limit inclusive.
   function automatic int unsigned cnt_width(input int unsigned limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Single-port data-cache arbiter between the store queue head
//                and the load queue.  One request is latched at a time and
//                presented to the cache until it responds.  Stores win by
//                default; a waiting load is forced after STARVE_LIMIT
//                consecutive store grants.  A pipeline flush drops an
//                outstanding load response but never aborts a store.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,

   input  logic        store_req,
   input  split_lsq_t  store_queue_req,
   output logic        store_ack,

   input  logic        load_req,
   input  split_lsq_t  load_queue_req,
   output logic        load_ack,
   output logic [31:0] load_rdata,
   output split_lsq_t  load_resp,

   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_rmask,
   output logic [3:0]  dmem_wmask,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_resp
);

   localparam int unsigned CNT_W = cnt_width(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   split_lsq_t       req_q, req_d;
   split_lsq_t       load_resp_q, load_resp_d;

   logic             store_grant;
   logic             load_grant;

   // Grants are only issued from IDLE and never in a flush cycle; the store
   // wins unless the waiting load has been starved long enough.
   always_comb begin
      store_grant = 1'b0;
      load_grant  = 1'b0;
      if (state_q == IDLE && !flush) begin
         if (store_req && (starve_cnt_q < LIMIT)) begin
            store_grant = 1'b1;
         end else if (load_req) begin
            load_grant = 1'b1;
         end
      end
   end

   // Next-state, request latch and starvation counter update.
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      req_d        = req_q;
      load_resp_d  = load_resp_q;
      case (state_q)
         IDLE: begin
            if (store_grant) begin
               state_d = STORE_WAIT;
               req_d   = store_queue_req;
               if (load_req && (starve_cnt_q != LIMIT)) begin
                  starve_cnt_d = starve_cnt_q + 1'b1;
               end
            end else if (load_grant) begin
               state_d      = LOAD_WAIT;
               req_d        = load_queue_req;
               load_resp_d  = load_queue_req;
               starve_cnt_d = '0;
            end
         end
         STORE_WAIT: begin
            // A flush never aborts a committed store.
            if (dmem_resp) begin
               state_d = IDLE;
            end
         end
         LOAD_WAIT: begin
            if (dmem_resp) begin
               state_d = IDLE;
            end else if (flush) begin
               state_d = LOAD_DROP;
            end
         end
         LOAD_DROP: begin
            // Cache still owes a response for the killed load; swallow it.
            if (dmem_resp) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset dominates flush and any cache response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         req_q        <= '0;
         load_resp_q  <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         req_q        <= req_d;
         load_resp_q  <= load_resp_d;
      end
   end

   // Cache request is driven from the latch; masks are qualified by state so
   // IDLE and LOAD_DROP present no access.
   always_comb begin
      dmem_addr  = req_q.addr;
      dmem_rmask = 4'b0000;
      dmem_wmask = 4'b0000;
      dmem_wdata = 32'h0000_0000;
      if (state_q == STORE_WAIT) begin
         dmem_wmask = req_q.wmask;
         dmem_wdata = req_q.wdata;
      end else if (state_q == LOAD_WAIT) begin
         dmem_rmask = req_q.rmask;
      end
   end

   // Acks follow the cache response in the same cycle; a load killed by a
   // coincident flush is not acknowledged.
   always_comb begin
      store_ack  = !rst && (state_q == STORE_WAIT) && dmem_resp;
      load_ack   = !rst && (state_q == LOAD_WAIT) && dmem_resp && !flush;
      load_rdata = dmem_rdata;
      load_resp  = load_resp_q;
   end

   // Writeback tags in the shared latch are carried only for load_resp.
   logic unused_req_bits;
   assign unused_req_bits = ^{req_q.rd, req_q.pd, req_q.rob_entry, req_q.pc};

endmodule : dmem_arbiter
`default_nettype wire
